// File: rtl/gf_pkg.sv
// Shared GF(2^8) constants, FSM state type and the AES affine helper for the
// sequential inverter (field polynomial x^8+x^4+x^3+x+1).
package gf_pkg;

  localparam int         GF_W     = 8;
  localparam logic [7:0] GF_RED   = 8'h1B;
  localparam logic [7:0] AFFINE_C = 8'h63;

  typedef enum logic [1:0] {
    IDLE,
    SQ,
    MUL,
    DONE
  } state_e;

  // Each output bit folds in the four bits cyclically above it, then adds 0x63.
  function automatic logic [GF_W-1:0] aesAffine(input logic [GF_W-1:0] v);
    logic [GF_W-1:0] o;
    o = '0;
    for (int i = 0; i < GF_W; i++) begin
      o[i] = v[i] ^ v[(i + 4) % GF_W] ^ v[(i + 5) % GF_W] ^
             v[(i + 6) % GF_W] ^ v[(i + 7) % GF_W] ^ AFFINE_C[i];
    end
    return o;
  endfunction

endpackage

// File: rtl/gf_mul_8.sv
// Combinational GF(2^8) multiplier, product reduced modulo 0x11B.
module gf_mul_8
  import gf_pkg::*;
(
  input  logic [GF_W-1:0] a_i,
  input  logic [GF_W-1:0] b_i,
  output logic [GF_W-1:0] p_o
);

  logic [GF_W-1:0] acc;
  logic [GF_W-1:0] shifted;

  // Shift-and-add: shifted holds a*x^i, reduced every step so it never leaves the field.
  always_comb begin
    acc     = '0;
    shifted = a_i;
    for (int i = 0; i < GF_W; i++) begin
      if (b_i[i]) begin
        acc = acc ^ shifted;
      end
      shifted = {shifted[GF_W-2:0], 1'b0} ^ (shifted[GF_W-1] ? GF_RED : '0);
    end
    p_o = acc;
  end

endmodule

// File: rtl/gf_inv_seq.sv
// Sequential GF(2^8) inverse x^254 by square-and-multiply on one shared multiplier.
// Define GF_INV_SEQ_AFFINE_EN to emit the AES S-box value instead of the raw inverse.
module gf_inv_seq
  import gf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [GF_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [GF_W-1:0] out_data
);

  state_e          state_q, state_d;
  logic [GF_W-1:0] s_q, s_d;
  logic [GF_W-1:0] r_q, r_d;
  logic [2:0]      k_q, k_d;
  logic [GF_W-1:0] mulA;
  logic [GF_W-1:0] prod;
  logic [GF_W-1:0] resultVal;

  // MUL folds the current square into the running product; every other state squares s.
  assign mulA = (state_q == MUL) ? r_q : s_q;

  gf_mul_8 u_mul (
    .a_i(mulA),
    .b_i(s_q),
    .p_o(prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      k_q     <= k_d;
    end
  end

  // The first square seeds r with x^2; the loop then accumulates x^4..x^128 into r.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    r_d     = r_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_data;
          k_d     = 3'd1;
          state_d = SQ;
        end
      end
      SQ: begin
        s_d = prod;
        if (k_q == 3'd1) begin
          r_d = prod;
          k_d = 3'd2;
        end else begin
          state_d = MUL;
        end
      end
      MUL: begin
        r_d = prod;
        if (k_q == 3'd7) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = SQ;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GF_INV_SEQ_AFFINE_EN
  assign resultVal = aesAffine(r_q);
`else
  assign resultVal = r_q;
`endif

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = (state_q == DONE) ? resultVal : '0;
  end

endmodule

// File: tb/tb_gf_inv_seq.sv
// Randomized and directed bench for gf_inv_seq against a behavioural inverse/S-box model.
module tb_gf_inv_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

`ifdef GF_INV_SEQ_AFFINE_EN
  localparam logic [7:0] EXP53 = 8'hED;
  localparam logic [7:0] EXP01 = 8'h7C;
  localparam logic [7:0] EXP00 = 8'h63;
  localparam logic [7:0] EXP02 = 8'h77;
`else
  localparam logic [7:0] EXP53 = 8'hCA;
  localparam logic [7:0] EXP01 = 8'h01;
  localparam logic [7:0] EXP00 = 8'h00;
  localparam logic [7:0] EXP02 = 8'h8D;
`endif

  int         tests;
  int         errors;
  int         cyc;
  int         lastAccept;
  int         mPhase;
  int         mCnt;
  int         mAcceptCnt;
  logic [7:0] mExp;
  logic [7:0] mOp;
  bit         checkEn;
  bit         sweepOn;
  bit         resSeen;

  gf_inv_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: carry-less product followed by long division by 0x11B.
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (15'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] refInv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (refMul(x, y[7:0]) == 8'h01) return y[7:0];
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] refAffine(input logic [7:0] v);
    logic [7:0] c;
    logic [7:0] o;
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      o[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
    end
    return o;
  endfunction

  function automatic logic [7:0] refOut(input logic [7:0] x);
`ifdef GF_INV_SEQ_AFFINE_EN
    return refAffine(refInv(x));
`else
    return refInv(x);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timing model: idle, busy for 13 edges after the accepting edge, then done until out_ready.
  always @(posedge clk) begin
    cyc++;
    if (checkEn && !rst && in_ready && in_valid) begin
      if (sweepOn && lastAccept >= 0) check("accept_spacing", cyc - lastAccept, 15);
      lastAccept = cyc;
    end
    if (rst) begin
      mPhase = 0;
    end else begin
      case (mPhase)
        0: if (in_valid) begin
          mPhase = 1;
          mCnt   = 0;
          mOp    = in_data;
          mExp   = refOut(in_data);
          mAcceptCnt++;
          resSeen = 1'b0;
        end
        1: begin
          mCnt++;
          if (mCnt == 13) mPhase = 2;
        end
        default: if (out_ready) mPhase = 0;
      endcase
    end
  end

  task automatic checkOutput();
    check("in_ready", in_ready, mPhase == 0);
    check("out_valid", out_valid, mPhase == 2);
    check("out_data", out_data, (mPhase == 2) ? mExp : 8'h00);
    if (sweepOn && out_valid && !resSeen) begin
      resSeen = 1'b1;
`ifndef GF_INV_SEQ_AFFINE_EN
      if (mOp != 8'h00) check("inv_product", refMul(out_data, mOp), 8'h01);
      else check("inv_zero", out_data, 8'h00);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  task automatic applyStimulus(input logic [7:0] x, input bit keepValid);
    int start;
    start    = mAcceptCnt;
    in_data  = x;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mAcceptCnt != start) break;
    end
    if (mAcceptCnt == start) check("accept_timeout", 0, 1);
    if (!keepValid) in_valid = 1'b0;
  endtask

  task automatic waitPhase(input int target);
    for (int i = 0; i < 40; i++) begin
      if (mPhase == target) break;
      @(negedge clk);
    end
    if (mPhase != target) check("wait_timeout", mPhase, target);
  endtask

  initial begin
    int         n;
    logic [7:0] held;
    tests      = 0;
    errors     = 0;
    cyc        = 0;
    lastAccept = -1;
    mPhase     = 0;
    mCnt       = 0;
    mAcceptCnt = 0;
    mExp       = 8'h00;
    mOp        = 8'h00;
    checkEn    = 1'b0;
    sweepOn    = 1'b0;
    resSeen    = 1'b1;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b0;

    check("pin_model_53", refOut(8'h53), EXP53);
    check("pin_model_01", refOut(8'h01), EXP01);
    check("pin_model_00", refOut(8'h00), EXP00);
    check("pin_model_02", refOut(8'h02), EXP02);

    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 8'h00);
    checkEn = 1'b1;
    rst     = 1'b0;
    @(negedge clk);

    // Fixed 13-cycle latency on 0x53.
    out_ready = 1'b1;
    applyStimulus(8'h53, 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("latency_53", n, 13);
    check("result_53", out_data, EXP53);
    waitPhase(0);

    applyStimulus(8'h01, 1'b0);
    waitPhase(2);
    check("result_01", out_data, EXP01);
    waitPhase(0);
    applyStimulus(8'h00, 1'b0);
    waitPhase(2);
    check("result_00", out_data, EXP00);
    waitPhase(0);
    applyStimulus(8'h02, 1'b0);
    waitPhase(2);
    check("result_02", out_data, EXP02);
    waitPhase(0);

    // Backpressure in DONE with an in_valid pulse that must be ignored.
    out_ready = 1'b0;
    applyStimulus(8'h01, 1'b0);
    waitPhase(2);
    held = out_data;
    check("hold_value", held, EXP01);
    for (int i = 0; i < 5; i++) begin
      check("hold_data", out_data, held);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      in_valid = (i == 1);
      in_data  = 8'hA5;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_idle", in_ready, 1);
    check("release_out_valid", out_valid, 0);

    // Abort mid-computation, then a clean operand.
    applyStimulus(8'h53, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (15) @(negedge clk);
    applyStimulus(8'h02, 1'b0);
    waitPhase(2);
    check("after_abort_02", out_data, EXP02);
    waitPhase(0);

    // Random operands with input noise while busy and random output stalls.
    for (int t = 0; t < 30; t++) begin
      waitPhase(0);
      out_ready = 1'b0;
      applyStimulus(8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 40; i++) begin
        if (mPhase == 2) break;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
    end
    waitPhase(0);

    // Exhaustive back-to-back sweep.
    out_ready  = 1'b1;
    lastAccept = -1;
    sweepOn    = 1'b1;
    for (int x = 0; x < 256; x++) begin
      applyStimulus(x[7:0], 1'b1);
    end
    in_valid = 1'b0;
    waitPhase(2);
    waitPhase(0);
    @(negedge clk);
    sweepOn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/gf_inv_seq.md
GF_INV_SEQ -- requirements
Module: gf_inv_seq

Interface
REQ-001 The parameter list SHALL be empty; field width is fixed at 8 bits, polynomial x^8+x^4+x^3+x+1 (0x11B).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_data is valid this cycle.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in_data  input  8  GF(2^8) operand x.
REQ-007 out_valid  output  1  out_data holds a result.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_data  output  8  x^254 (multiplicative inverse), or S-box value per REQ-024.

Function
REQ-010 The block SHALL compute x^254 by square-and-multiply over one shared GF(2^8) multiplier instance, one multiply per cycle.
REQ-011 FSM states SHALL be IDLE, SQ, MUL, DONE; a 3-bit step counter k SHALL track loop index 1..7.
REQ-012 IDLE: in_ready=1; on in_valid=1 load s<=in_data, k<=1, go to SQ.
REQ-013 SQ with k=1: s<=s*s, r<=s*s, k<=2, stay in SQ.
REQ-014 SQ with k>=2: s<=s*s, go to MUL.
REQ-015 MUL: r<=r*s; if k=7 go to DONE, else k<=k+1 and go to SQ.
REQ-016 Latency SHALL be fixed at 13 compute cycles: out_valid is high in the cycle following the 13th edge after the accepting edge, independent of data.
REQ-017 DONE: out_valid=1 and out_data held stable until out_ready=1; on that edge go to IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored (no buffering, no overwrite).
REQ-019 out_valid and in_ready SHALL never be high in the same cycle; back-to-back throughput is one operand per 15 cycles (accept, 13 compute, handshake).
REQ-020 in_data=0x00 SHALL yield out_data=0x00 (natural result of x^254); no special-case path is required.
REQ-021 out_data SHALL be 0x00 whenever out_valid=0.

Reset
REQ-022 rst=1 at any edge SHALL force IDLE, s=r=0x00, k=0, out_valid=0, in_ready=1 (after the edge), out_data=0x00, aborting any operation in progress without emitting a result.
REQ-023 rst SHALL take priority over every handshake sampled on the same edge.

Configuration
REQ-024 Macro GF_INV_SEQ_AFFINE_EN: when defined, out_data SHALL be the AES affine transform of r (bit i = r[i]^r[i+4]^r[i+5]^r[i+6]^r[i+7]^c[i], indices mod 8, c=0x63), i.e. the AES S-box; when undefined, out_data SHALL be r directly. Latency is identical in both builds (affine is combinational on the output).

Structure
REQ-025 A shared package gf_pkg SHALL hold the reduction constant 8'h1B, field width 8, affine constant 8'h63 and the FSM state enum.
REQ-026 The multiplier SHALL be a separate combinational sub-module gf_mul_8 (two 8-bit inputs, 8-bit product mod 0x11B); its operand muxing (s,s or r,s) belongs in gf_inv_seq.

Verification
REQ-027 in_data=0x53, out_ready=1 -> out_valid after exactly 13 cycles, out_data=0xCA (affine build: 0xED).
REQ-028 in_data=0x01 -> 0x01 (affine: 0x7C); in_data=0x00 -> 0x00 (affine: 0x63); in_data=0x02 -> 0x8D (affine: 0x77).
REQ-029 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, a new in_valid pulse is not accepted; release -> IDLE next cycle.
REQ-030 rst asserted at compute cycle 6 with operand 0x53 -> next cycle IDLE, out_valid=0, no result emitted; subsequent 0x02 yields 0x8D after 13 cycles.
REQ-031 Exhaustive sweep 0x00..0xFF back-to-back -> every result r satisfies r*x=0x01 (x!=0), and every accept is spaced 15 cycles apart.
